// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer datapath.
// Holds the queue FSM state type and the default buffer geometry. The FIR slice
// imports the same TAPS value so the burst length always matches its
// coefficient count.
package eq_pkg;

  localparam int unsigned EQ_DEPTH  = 1024;
  localparam int unsigned EQ_ADDR_W = 10;
  localparam int unsigned EQ_TAPS   = 1021;

  typedef enum logic [1:0] {
    FILL,
    RDY,
    READ
  } queue_state_t;

endpackage

// File: rtl/queue_dpram.sv
// Simple dual-port RAM, one write port and one read port.
// Synchronous write; synchronous read with a 1-cycle registered output.
// There is no reset on the array or the read register, so it can map to block RAM.
// Ports:
//   clk      clock
//   wr_en    write strobe; stores wr_data at wr_addr
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data is updated on the next edge
//   rd_addr  read address
//   rd_data  registered read data
module queue_dpram #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WIDTH  = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/eq_sample_queue.sv
// Stereo circular sample buffer that feeds one FIR slice.
// It stores every accepted stereo sample. Once TAPS samples have been
// collected, each accepted write triggers a burst: the most recent TAPS
// samples are read out oldest first. During the burst, sequencing is high for
// exactly TAPS consecutive cycles.
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   wrt_smpl    write strobe; one sample per high cycle
//   lft_smpl    left sample to store
//   rght_smpl   right sample to store
//   sequencing  high for TAPS cycles per burst
//   lft_out     left sample being read out; valid while sequencing is high
//   rght_out    right sample being read out; valid while sequencing is high
module eq_sample_queue
  import eq_pkg::*;
#(
  parameter int unsigned DEPTH  = EQ_DEPTH,
  parameter int unsigned ADDR_W = EQ_ADDR_W,
  parameter int unsigned TAPS   = EQ_TAPS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out
);

  localparam int unsigned CNT_W = $clog2(TAPS + 1);
  localparam logic [ADDR_W-1:0] BACK_OFF = ADDR_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  TAPS_C   = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(TAPS - 1);

  queue_state_t      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              rd_vld_q;
  logic              wr_en, rd_en;
  logic [31:0]       rd_data;

  queue_dpram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (32)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data ({lft_smpl, rght_smpl}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    unique case (state_q)
      FILL, RDY: begin
        // The tail of the previous burst is still draining while sequencing
        // is high, so writes are dropped until it falls.
        if (wrt_smpl && !sequencing) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (fill_cnt_q != TAPS_C) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
          if (fill_cnt_q >= LAST_C) begin
            state_d  = READ;
            // Oldest of the last TAPS samples, including the one being written.
            rd_ptr_d = wr_ptr_q - BACK_OFF;
          end
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (rd_cnt_q == LAST_C) begin
          rd_cnt_d = '0;
          state_d  = RDY;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      rd_cnt_q   <= '0;
      rd_vld_q   <= 1'b0;
      sequencing <= 1'b0;
      lft_out    <= '0;
      rght_out   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      // The RAM output register adds one cycle; outputs follow one cycle later.
      rd_vld_q   <= rd_en;
      sequencing <= rd_vld_q;
      if (rd_vld_q) begin
        {lft_out, rght_out} <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_eq_sample_queue.sv
module tb_eq_sample_queue;
  import eq_pkg::*;

  localparam int TAPS = EQ_TAPS;

  logic               clk;
  logic               rst_n;
  logic               wrt_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;

  int total;
  int bad;
  logic [31:0] hist [$];

  eq_sample_queue #(
    .DEPTH  (EQ_DEPTH),
    .ADDR_W (EQ_ADDR_W),
    .TAPS   (EQ_TAPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one write strobe on a single rising edge; returns on the
  // falling edge right after that edge.
  task automatic drive_write(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    wrt_smpl  = 1'b1;
    lft_smpl  = l;
    rght_smpl = r;
    @(negedge clk);
    wrt_smpl  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sequencing !== 1'b0 || lft_out !== 16'sd0 || rght_out !== 16'sd0) begin
      bad++;
      $display("FAIL reset_outputs got seq=%b l=%h r=%h want seq=0 l=0000 r=0000",
               sequencing, lft_out, rght_out);
    end
    rst_n = 1'b1;
    hist.delete();
  endtask

  // 1020 writes: one short of a full window, so no burst may start.
  task automatic test_fill();
    for (int i = 0; i < TAPS - 1; i++) begin
      drive_write(16'(i), 16'(-i));
      hist.push_back({16'(i), 16'(-i)});
      for (int c = 0; c < 3; c++) begin
        if (c > 0) @(negedge clk);
        total++;
        if (sequencing !== 1'b0 || lft_out !== 16'sd0 || rght_out !== 16'sd0) begin
          bad++;
          $display("FAIL fill_quiet[%0d] got seq=%b l=%h r=%h want seq=0 l=0000 r=0000",
                   i, sequencing, lft_out, rght_out);
        end
      end
    end
  endtask

  task automatic test_first_burst();
    logic [31:0] exp;
    drive_write(16'sd1020, -16'sd1020);
    hist.push_back({16'sd1020, -16'sd1020});
    @(negedge clk);
    total++;
    if (sequencing !== 1'b0) begin
      bad++;
      $display("FAIL first_latency got seq=%b want 0", sequencing);
    end
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      exp = hist[hist.size() - TAPS + i];
      total++;
      if (sequencing !== 1'b1 || lft_out !== exp[31:16] || rght_out !== exp[15:0]) begin
        bad++;
        $display("FAIL first_burst[%0d] got seq=%b l=%h r=%h want seq=1 l=%h r=%h",
                 i, sequencing, lft_out, rght_out, exp[31:16], exp[15:0]);
      end
    end
    @(negedge clk);
    total++;
    if (sequencing !== 1'b0) begin
      bad++;
      $display("FAIL first_end got seq=%b want 0", sequencing);
    end
  endtask

  // Writes 1021..1030; the last burst spans 10..1030 and crosses address 1023->0.
  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int v = 1021; v <= 1030; v++) begin
      drive_write(16'(v), 16'(-v));
      hist.push_back({16'(v), 16'(-v)});
      @(negedge clk);
      total++;
      if (sequencing !== 1'b0) begin
        bad++;
        $display("FAIL b2b_latency[%0d] got seq=%b want 0", v, sequencing);
      end
      for (int i = 0; i < TAPS; i++) begin
        @(negedge clk);
        exp = hist[hist.size() - TAPS + i];
        total++;
        if (sequencing !== 1'b1 || lft_out !== exp[31:16] || rght_out !== exp[15:0]) begin
          bad++;
          $display("FAIL b2b_burst[%0d][%0d] got seq=%b l=%h r=%h want seq=1 l=%h r=%h",
                   v, i, sequencing, lft_out, rght_out, exp[31:16], exp[15:0]);
        end
      end
      @(negedge clk);
      total++;
      if (sequencing !== 1'b0) begin
        bad++;
        $display("FAIL b2b_end[%0d] got seq=%b want 0", v, sequencing);
      end
    end
  endtask

  // A 0x7FFF write 100 cycles into a burst must be dropped entirely.
  task automatic test_write_during_burst();
    logic [31:0] exp;
    for (int b = 0; b < 2; b++) begin
      drive_write(16'(1031 + b), 16'(-(1031 + b)));
      hist.push_back({16'(1031 + b), 16'(-(1031 + b))});
      @(negedge clk);
      total++;
      if (sequencing !== 1'b0) begin
        bad++;
        $display("FAIL drop_latency[%0d] got seq=%b want 0", b, sequencing);
      end
      for (int i = 0; i < TAPS; i++) begin
        @(negedge clk);
        exp = hist[hist.size() - TAPS + i];
        total++;
        if (sequencing !== 1'b1 || lft_out !== exp[31:16] || rght_out !== exp[15:0]) begin
          bad++;
          $display("FAIL drop_burst[%0d][%0d] got seq=%b l=%h r=%h want seq=1 l=%h r=%h",
                   b, i, sequencing, lft_out, rght_out, exp[31:16], exp[15:0]);
        end
        if (b == 0 && i == 100) begin
          wrt_smpl  = 1'b1;
          lft_smpl  = 16'sh7FFF;
          rght_smpl = 16'sh7FFF;
        end else begin
          wrt_smpl = 1'b0;
        end
      end
      @(negedge clk);
      total++;
      if (sequencing !== 1'b0) begin
        bad++;
        $display("FAIL drop_end[%0d] got seq=%b want 0", b, sequencing);
      end
    end
  endtask

  // Reset 500 cycles into a burst, then refill with fresh data.
  task automatic test_reset_mid_burst();
    logic [31:0] exp;
    drive_write(16'sd2000, -16'sd2000);
    hist.push_back({16'sd2000, -16'sd2000});
    @(negedge clk);
    for (int i = 0; i <= 500; i++) begin
      @(negedge clk);
      exp = hist[hist.size() - TAPS + i];
      total++;
      if (sequencing !== 1'b1 || lft_out !== exp[31:16] || rght_out !== exp[15:0]) begin
        bad++;
        $display("FAIL rst_pre_burst[%0d] got seq=%b l=%h r=%h want seq=1 l=%h r=%h",
                 i, sequencing, lft_out, rght_out, exp[31:16], exp[15:0]);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (sequencing !== 1'b0 || lft_out !== 16'sd0 || rght_out !== 16'sd0) begin
      bad++;
      $display("FAIL rst_async got seq=%b l=%h r=%h want seq=0 l=0000 r=0000",
               sequencing, lft_out, rght_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    for (int i = 0; i < TAPS - 1; i++) begin
      drive_write(16'(3000 + i), ~16'(i));
      hist.push_back({16'(3000 + i), ~16'(i)});
      for (int c = 0; c < 3; c++) begin
        if (c > 0) @(negedge clk);
        total++;
        if (sequencing !== 1'b0 || lft_out !== 16'sd0 || rght_out !== 16'sd0) begin
          bad++;
          $display("FAIL rst_refill_quiet[%0d] got seq=%b l=%h r=%h want seq=0 l=0000 r=0000",
                   i, sequencing, lft_out, rght_out);
        end
      end
    end
    drive_write(16'(3000 + TAPS - 1), ~16'(TAPS - 1));
    hist.push_back({16'(3000 + TAPS - 1), ~16'(TAPS - 1)});
    @(negedge clk);
    total++;
    if (sequencing !== 1'b0) begin
      bad++;
      $display("FAIL rst_latency got seq=%b want 0", sequencing);
    end
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      exp = hist[hist.size() - TAPS + i];
      total++;
      if (sequencing !== 1'b1 || lft_out !== exp[31:16] || rght_out !== exp[15:0]) begin
        bad++;
        $display("FAIL rst_post_burst[%0d] got seq=%b l=%h r=%h want seq=1 l=%h r=%h",
                 i, sequencing, lft_out, rght_out, exp[31:16], exp[15:0]);
      end
    end
    @(negedge clk);
    total++;
    if (sequencing !== 1'b0) begin
      bad++;
      $display("FAIL rst_end got seq=%b want 0", sequencing);
    end
  endtask

  // Full-scale positive and negative values must come back bit-exact.
  task automatic test_extremes();
    logic [31:0] exp;
    logic [31:0] pats [4];
    pats[0] = {16'h8000, 16'h7FFF};
    pats[1] = {16'h7FFF, 16'h8000};
    pats[2] = {16'h8000, 16'h8000};
    pats[3] = {16'h7FFF, 16'h7FFF};
    for (int p = 0; p < 4; p++) begin
      drive_write(pats[p][31:16], pats[p][15:0]);
      hist.push_back(pats[p]);
      @(negedge clk);
      for (int i = 0; i < TAPS; i++) begin
        @(negedge clk);
        exp = hist[hist.size() - TAPS + i];
        total++;
        if (sequencing !== 1'b1 || lft_out !== exp[31:16] || rght_out !== exp[15:0]) begin
          bad++;
          $display("FAIL ext_burst[%0d][%0d] got seq=%b l=%h r=%h want seq=1 l=%h r=%h",
                   p, i, sequencing, lft_out, rght_out, exp[31:16], exp[15:0]);
        end
      end
      total++;
      if (lft_out !== pats[p][31:16] || rght_out !== pats[p][15:0]) begin
        bad++;
        $display("FAIL ext_newest[%0d] got l=%h r=%h want l=%h r=%h",
                 p, lft_out, rght_out, pats[p][31:16], pats[p][15:0]);
      end
      @(negedge clk);
      total++;
      if (sequencing !== 1'b0) begin
        bad++;
        $display("FAIL ext_end[%0d] got seq=%b want 0", p, sequencing);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    wrt_smpl  = 1'b0;
    lft_smpl  = '0;
    rght_smpl = '0;
    test_reset();
    test_fill();
    test_first_burst();
    test_back_to_back();
    test_write_during_burst();
    test_reset_mid_burst();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
